// File: rtl/ctrl_rr_arbiter.sv
// ctrl_rr_arbiter: round-robin arbiter that shares the control-bus loader among
// eight requesters. One requester is granted at a time (one-hot EN). The grant
// is held for the requester's whole BUSY window, and then priority rotates past it.
//
// Optional feature macro: CTRL_ARB_TIMEOUT_EN. When it is defined, a watchdog
// revokes a grant if BUSY does not rise within TIMEOUT cycles.
//
// Ports:
//   i_clk           system clock, all state on rising edge
//   i_rst           asynchronous active-high reset
//   i_request[7:0]  level request per requester (bit i = requester i+1)
//   i_busy[7:0]     per-requester busy, only the granted bit is observed
//   o_en[7:0]       one-hot grant enable, all zero when no grant
//   o_request_ok    one-hot acknowledge, same timing as o_en
//   o_grant_id      index of current/last granted requester
//   o_grant_valid   high while any o_en bit is high
//   o_timeout_err   one-cycle pulse when the watchdog revokes a grant
//   o_err_id        index of the last revoked requester
module ctrl_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_request,
    input  logic [7:0] i_busy,
    output logic [7:0] o_en,
    output logic [7:0] o_request_ok,
    output logic [2:0] o_grant_id,
    output logic       o_grant_valid,
    output logic       o_timeout_err,
    output logic [2:0] o_err_id
);

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    // Legal watchdog range; checked in both builds so that a bad value is caught early.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("ctrl_rr_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   r_gid;
    logic [IDW-1:0]   w_gid_nxt;
    logic [N-1:0]     r_en;
    logic [N-1:0]     w_en_nxt;
    logic             r_valid;
    logic [IDW-1:0]   w_winner;

`ifdef CTRL_ARB_TIMEOUT_EN
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_terr;
    logic             w_terr_nxt;
    logic [IDW-1:0]   r_err_id;
    logic [IDW-1:0]   w_err_id_nxt;
`endif

    // Rotating priority search: first requesting index at or after r_ptr, wrapping 7 -> 0.
    always_comb begin : p_pick
        logic           v_found;
        logic [IDW-1:0] v_idx;
        w_winner = r_ptr;
        v_found  = 1'b0;
        v_idx    = r_ptr;
        for (int k = 0; k < N; k++) begin
            v_idx = r_ptr + IDW'(k);
            if (!v_found && i_request[v_idx]) begin
                w_winner = v_idx;
                v_found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        w_en_nxt    = r_en;
`ifdef CTRL_ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_terr_nxt   = 1'b0;
        w_err_id_nxt = r_err_id;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (|i_request) begin
                    w_state_nxt = S_GRANT;
                    w_gid_nxt   = w_winner;
                    w_en_nxt    = N'(1) << w_winner;
`ifdef CTRL_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            S_GRANT: begin
                // BUSY wins over withdrawal; withdrawal wins over the watchdog.
                if (i_busy[r_gid]) begin
                    w_state_nxt = S_ACTIVE;
                end else if (!i_request[r_gid]) begin
                    w_state_nxt = S_RELEASE;
                end
`ifdef CTRL_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = S_RELEASE;
                    w_terr_nxt   = 1'b1;
                    w_err_id_nxt = r_gid;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
`endif
            end
            S_ACTIVE: begin
                if (!i_busy[r_gid]) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The grant is still visible during RELEASE; it drops on the exit edge.
                w_state_nxt = S_IDLE;
                w_en_nxt    = '0;
                w_ptr_nxt   = r_gid + IDW'(1);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_en    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
            r_en    <= w_en_nxt;
            r_valid <= |w_en_nxt;
        end
    end

`ifdef CTRL_ARB_TIMEOUT_EN
    // Watchdog counter and error reporting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_terr   <= 1'b0;
            r_err_id <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_terr   <= w_terr_nxt;
            r_err_id <= w_err_id_nxt;
        end
    end

    assign o_timeout_err = r_terr;
    assign o_err_id      = r_err_id;
`else
    assign o_timeout_err = 1'b0;
    assign o_err_id      = '0;
`endif

    assign o_en          = r_en;
    assign o_request_ok  = r_en;
    assign o_grant_id    = r_gid;
    assign o_grant_valid = r_valid;

endmodule

// File: tb/tb_ctrl_rr_arbiter.sv
// Self-checking bench for ctrl_rr_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_ctrl_rr_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] busy = 8'h00;
    logic [7:0] en;
    logic [7:0] req_ok;
    logic [2:0] gid;
    logic       gvalid;
    logic       terr;
    logic [2:0] err_id;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_rr_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_request     (req),
        .i_busy        (busy),
        .o_en          (en),
        .o_request_ok  (req_ok),
        .o_grant_id    (gid),
        .o_grant_valid (gvalid),
        .o_timeout_err (terr),
        .o_err_id      (err_id)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus and how far along the ownership is.
    int         m_owner;
    bit         m_owned;    // a grant exists (EN visible)
    bit         m_waiting;  // granted, BUSY not yet seen
    bit         m_closing;  // ownership ends on the next edge
    int         m_age;      // waiting cycles elapsed
    int         m_ptr;
    logic [2:0] m_gid;
    logic [2:0] m_errid;
    logic       m_terr;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_owned = 0; m_waiting = 0; m_closing = 0; m_age = 0;
        m_ptr = 0; m_gid = 3'd0; m_errid = 3'd0; m_terr = 1'b0;
    endtask

    // One clock edge of arbitration rules, applied to the inputs sampled at that edge.
    task automatic model_step(input logic [7:0] r, input logic [7:0] b);
        bit found;
        m_terr = 1'b0;
        if (!m_owned) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_owned = 1; m_waiting = 1; m_closing = 0; m_age = 0;
                m_gid   = 3'(m_owner);
            end
        end else if (m_closing) begin
            m_owned = 0; m_closing = 0;
            m_ptr   = (m_owner + 1) % 8;
        end else if (m_waiting) begin
            if (b[m_owner]) begin
                m_waiting = 0;
            end else if (!r[m_owner]) begin
                m_closing = 1;
            end else begin
                m_age++;
`ifdef CTRL_ARB_TIMEOUT_EN
                if (m_age == TO) begin
                    m_closing = 1;
                    m_terr    = 1'b1;
                    m_errid   = 3'(m_owner);
                end
`endif
            end
        end else if (!b[m_owner]) begin
            m_closing = 1;
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_en;
        exp_en = 8'h00;
        if (m_owned) exp_en = 8'h01 << m_owner;
        check("en",         en,          exp_en);
        check("request_ok", req_ok,      exp_en);
        check("grant_id",   8'(gid),     8'(m_gid));
        check("grant_valid",8'(gvalid),  8'(exp_en != 8'h00));
        check("timeout_err",8'(terr),    8'(m_terr));
        check("err_id",     8'(err_id),  8'(m_errid));
    endtask

    // Drive inputs, take one edge, update the model, compare on the falling edge.
    task automatic cycle(input logic [7:0] r, input logic [7:0] b);
        req  = r;
        busy = b;
        @(posedge clk);
        model_step(r, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'hFF;
        busy = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en",     en,           8'h00);
        check("rst_ok",     req_ok,       8'h00);
        check("rst_valid",  8'(gvalid),   8'h00);
        check("rst_gid",    8'(gid),      8'h00);
        check("rst_terr",   8'(terr),     8'h00);
        model_reset();
        rst = 1'b0;
        req = 8'h00;
    endtask

    // Full transaction from IDLE: grant, BUSY for n cycles, release, one idle gap.
    task automatic serve(input logic [7:0] r, input int busy_cycles, output int g);
        cycle(r, 8'h00);
        g = int'(gid);
        for (int i = 0; i < busy_cycles; i++) cycle(r, 8'h01 << g);
        cycle(r, 8'h00);
        cycle(r, 8'h00);
        check("gap_en", en, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        logic [7:0] r;
        model_reset();

        // Single transaction on requester index 2.
        do_reset();
        cycle(8'h04, 8'h00);
        check("single_grant", en, 8'h04);
        cycle(8'h04, 8'h00);
        cycle(8'h04, 8'h04);
        cycle(8'h04, 8'h04);
        cycle(8'h00, 8'h00);
        check("single_hold", en, 8'h04);
        cycle(8'h00, 8'h00);
        check("single_release", en, 8'h00);
        check("single_gid_kept", 8'(gid), 8'd2);
        serve(8'h09, 1, g);
        check("ptr_after_single", 8'(g), 8'd3);

        // Rotation with all requesting.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            serve(8'hFF, 1, g);
            check("rotation", 8'(g), 8'(i % 8));
        end

        // Simultaneous requests with pointer at 5.
        do_reset();
        serve(8'h10, 1, g);
        check("ptr_setup", 8'(g), 8'd4);
        serve(8'h09, 1, g);
        check("ptr_wrap_first", 8'(g), 8'd0);
        serve(8'h09, 1, g);
        check("ptr_wrap_second", 8'(g), 8'd3);

        // Abandon before BUSY.
        do_reset();
        cycle(8'h02, 8'h00);
        check("abandon_grant", en, 8'h02);
        cycle(8'h00, 8'h00);
        check("abandon_release_en", en, 8'h02);
        check("abandon_no_err", 8'(terr), 8'h00);
        cycle(8'h00, 8'h00);
        check("abandon_idle", en, 8'h00);

        // Watchdog on requester 7.
        do_reset();
        cycle(8'h80, 8'h00);
        repeat (3) cycle(8'h80, 8'h00);
`ifdef CTRL_ARB_TIMEOUT_EN
        cycle(8'h80, 8'h00);
        check("wd_pulse", 8'(terr), 8'h01);
        check("wd_err_id", 8'(err_id), 8'd7);
        cycle(8'h00, 8'h00);
        check("wd_pulse_end", 8'(terr), 8'h00);
        check("wd_revoked", en, 8'h00);
        check("wd_err_id_held", 8'(err_id), 8'd7);
`else
        repeat (10) cycle(8'h80, 8'h00);
        check("no_wd_held", en, 8'h80);
        check("no_wd_err", 8'(terr), 8'h00);
        cycle(8'h00, 8'h00);
        cycle(8'h00, 8'h00);
`endif

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cycle(8'h20, 8'h00);
        cycle(8'h20, 8'h20);
        #2 rst = 1'b1;
        #1;
        check("async_rst_en", en, 8'h00);
        check("async_rst_valid", 8'(gvalid), 8'h00);
        check("async_rst_gid", 8'(gid), 8'h00);
        check("async_rst_terr", 8'(terr), 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) cycle(r, 8'h00);
            else cycle(r, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
